// File: rtl/spi_arb_pkg.sv
// Shared definitions for the SPI transaction arbiter: FSM state encoding and
// the sizing helper for the counter shared by the timeout and guard-gap phases.
package spi_arb_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_LAUNCH = 2'd1,
    ST_WAIT   = 2'd2,
    ST_GAP    = 2'd3
  } arb_state_e;

  // Enough bits to count up to the longer of the two phases.
  function automatic int cnt_width(input int timeout_cycles, input int gap_cycles);
    int m;
    m = (timeout_cycles > gap_cycles) ? timeout_cycles : gap_cycles;
    return (m < 2) ? 1 : $clog2(m);
  endfunction

endpackage

// File: rtl/spi_txn_arbiter_rr_pick.sv
// Combinational round-robin selector: first asserted request strictly after
// the pointer, wrapping modulo NUM_REQ. Shared with other resource arbiters.
module rr_pick #(
  parameter int NUM_REQ = 4,
  parameter int IDX_W   = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [IDX_W-1:0]   ptr,
  output logic [NUM_REQ-1:0] grant,
  output logic [IDX_W-1:0]   idx,
  output logic               any
);

  always_comb begin
    int j;
    j     = 0;
    grant = '0;
    idx   = '0;
    any   = 1'b0;
    for (int i = 1; i <= NUM_REQ; i++) begin
      j = (int'(ptr) + i) % NUM_REQ;
      if (!any && req[j]) begin
        any      = 1'b1;
        grant[j] = 1'b1;
        idx      = IDX_W'(j);
      end
    end
  end

endmodule

// File: rtl/spi_txn_arbiter.sv
// Round-robin arbiter sharing one SPI shift engine among NUM_REQ requesters:
// accept, launch, wait for done or timeout, then hold all CS high for a guard gap.
module spi_txn_arbiter
  import spi_arb_pkg::*;
#(
  parameter int NUM_REQ        = 4,
  parameter int DATA_W         = 16,
  parameter int GAP_CYCLES     = 4,
  parameter int TIMEOUT_CYCLES = 256
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic [NUM_REQ-1:0]          req_valid,
  input  logic [NUM_REQ*DATA_W-1:0]   req_data,
  output logic [NUM_REQ-1:0]          req_ready,
  output logic [NUM_REQ-1:0]          req_done,
  output logic [NUM_REQ-1:0]          req_err,
  output logic                        m_start,
  output logic [DATA_W-1:0]           m_data,
  input  logic                        m_done,
  output logic [NUM_REQ-1:0]          spi_cs_n,
  output logic                        busy,
  output logic [$clog2(NUM_REQ)-1:0]  grant_id
);

  localparam int IDX_W = $clog2(NUM_REQ);
  localparam int CNT_W = cnt_width(TIMEOUT_CYCLES, GAP_CYCLES);
  // The count is cleared on entering WAIT, so the final WAIT cycle is the one
  // whose increment would bring it to TIMEOUT_CYCLES-1.
  localparam logic [CNT_W-1:0] TO_LAST  = CNT_W'(TIMEOUT_CYCLES - 2);
  localparam logic [CNT_W-1:0] GAP_LAST = CNT_W'(GAP_CYCLES - 1);

  arb_state_e          state_q, state_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic [IDX_W-1:0]    ptr_q, ptr_d;
  logic [IDX_W-1:0]    grant_q, grant_d;
  logic                m_start_q, m_start_d;
  logic [DATA_W-1:0]   m_data_q, m_data_d;
  logic [NUM_REQ-1:0]  cs_n_q, cs_n_d;
  logic [NUM_REQ-1:0]  done_q, done_d;
  logic [NUM_REQ-1:0]  err_q, err_d;

  logic [NUM_REQ-1:0]  pick_grant;
  logic [IDX_W-1:0]    pick_idx;
  logic                pick_any;
  logic                accept;
  logic                timeout_hit;
  logic                gap_last;

  rr_pick #(
    .NUM_REQ (NUM_REQ),
    .IDX_W   (IDX_W)
  ) u_rr_pick (
    .req   (req_valid),
    .ptr   (ptr_q),
    .grant (pick_grant),
    .idx   (pick_idx),
    .any   (pick_any)
  );

  assign accept      = (state_q == ST_IDLE) && pick_any;
  assign timeout_hit = (cnt_q == TO_LAST);
  assign gap_last    = (cnt_q == GAP_LAST);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q   <= ST_IDLE;
      cnt_q     <= '0;
      ptr_q     <= IDX_W'(NUM_REQ - 1);
      grant_q   <= '0;
      m_start_q <= 1'b0;
      m_data_q  <= '0;
      cs_n_q    <= '1;
      done_q    <= '0;
      err_q     <= '0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      ptr_q     <= ptr_d;
      grant_q   <= grant_d;
      m_start_q <= m_start_d;
      m_data_q  <= m_data_d;
      cs_n_q    <= cs_n_d;
      done_q    <= done_d;
      err_q     <= err_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      ST_IDLE: begin
        if (accept) state_d = ST_LAUNCH;
      end
      ST_LAUNCH: begin
        state_d = ST_WAIT;
        cnt_d   = '0;
      end
      ST_WAIT: begin
        if (m_done || timeout_hit) begin
          state_d = ST_GAP;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      ST_GAP: begin
        if (gap_last) state_d = ST_IDLE;
        else          cnt_d   = cnt_q + 1'b1;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Registered outputs; done takes priority over a coincident timeout.
  always_comb begin
    m_start_d = 1'b0;
    m_data_d  = m_data_q;
    cs_n_d    = cs_n_q;
    done_d    = '0;
    err_d     = '0;
    grant_d   = grant_q;
    ptr_d     = ptr_q;
    case (state_q)
      ST_IDLE: begin
        if (accept) begin
          m_start_d = 1'b1;
          m_data_d  = req_data[int'(pick_idx)*DATA_W +: DATA_W];
          grant_d   = pick_idx;
          ptr_d     = pick_idx;
          cs_n_d    = ~pick_grant;
        end
      end
      ST_WAIT: begin
        if (m_done) begin
          done_d = NUM_REQ'(1) << grant_q;
          cs_n_d = '1;
        end else if (timeout_hit) begin
          err_d  = NUM_REQ'(1) << grant_q;
          cs_n_d = '1;
        end
      end
      ST_GAP:  cs_n_d = '1;
      default: ;
    endcase
  end

  assign req_ready = (state_q == ST_IDLE) ? pick_grant : '0;
  assign req_done  = done_q;
  assign req_err   = err_q;
  assign m_start   = m_start_q;
  assign m_data    = m_data_q;
  assign spi_cs_n  = cs_n_q;
  assign busy      = (state_q != ST_IDLE);
  assign grant_id  = grant_q;

endmodule

// File: tb/tb_spi_txn_arbiter.sv
// Directed bench for spi_txn_arbiter: reset, single transfer, round-robin order,
// timeout, done/timeout collision, stray m_done and reset mid-transfer.
module tb_spi_txn_arbiter;

  localparam int NUM_REQ = 4;
  localparam int DATA_W  = 16;
  localparam int GAP     = 4;
  localparam int TO      = 256;

  logic                       clk = 1'b0;
  logic                       rst;
  logic [NUM_REQ-1:0]         req_valid;
  logic [NUM_REQ*DATA_W-1:0]  req_data;
  logic [NUM_REQ-1:0]         req_ready;
  logic [NUM_REQ-1:0]         req_done;
  logic [NUM_REQ-1:0]         req_err;
  logic                       m_start;
  logic [DATA_W-1:0]          m_data;
  logic                       m_done;
  logic [NUM_REQ-1:0]         spi_cs_n;
  logic                       busy;
  logic [1:0]                 grant_id;

  int checks = 0;
  int errors = 0;

  spi_txn_arbiter #(
    .NUM_REQ        (NUM_REQ),
    .DATA_W         (DATA_W),
    .GAP_CYCLES     (GAP),
    .TIMEOUT_CYCLES (TO)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .req_valid (req_valid),
    .req_data  (req_data),
    .req_ready (req_ready),
    .req_done  (req_done),
    .req_err   (req_err),
    .m_start   (m_start),
    .m_data    (m_data),
    .m_done    (m_done),
    .spi_cs_n  (spi_cs_n),
    .busy      (busy),
    .grant_id  (grant_id)
  );

  always #5 clk = ~clk;

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation did not finish, got timeout want completion");
    $fatal(1);
  end

  task automatic tick();
    @(negedge clk);
  endtask

  task automatic do_reset();
    rst = 1'b0; req_valid = '0; m_done = 1'b0;
    tick(); tick();
    rst = 1'b1;
    tick();
  endtask

  task automatic test_reset();
    rst = 1'b1; req_valid = '0; req_data = '0; m_done = 1'b0;
    #2 rst = 1'b0;
    tick();
    checks++; if (m_start !== 1'b0) begin errors++; $display("FAIL rst_m_start: got %b want 0", m_start); end
    checks++; if (m_data !== 16'h0000) begin errors++; $display("FAIL rst_m_data: got %h want 0000", m_data); end
    checks++; if (spi_cs_n !== 4'b1111) begin errors++; $display("FAIL rst_cs: got %b want 1111", spi_cs_n); end
    checks++; if (req_done !== 4'b0000 || req_err !== 4'b0000) begin errors++; $display("FAIL rst_done_err: got %b/%b want 0000/0000", req_done, req_err); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL rst_busy: got %b want 0", busy); end
    checks++; if (grant_id !== 2'd0) begin errors++; $display("FAIL rst_grant: got %0d want 0", grant_id); end
    req_valid = 4'b1111; #1;
    checks++; if (req_ready !== 4'b0001) begin errors++; $display("FAIL rst_ready_tie: got %b want 0001", req_ready); end
    req_valid = '0;
    rst = 1'b1;
    tick();
  endtask

  task automatic test_single();
    bit bad;
    req_data[1*DATA_W +: DATA_W] = 16'hA5C3;
    req_valid = 4'b0010; #1;
    checks++; if (req_ready !== 4'b0010) begin errors++; $display("FAIL single_ready: got %b want 0010", req_ready); end
    tick(); req_valid = '0;
    checks++; if (m_start !== 1'b1) begin errors++; $display("FAIL single_start: got %b want 1", m_start); end
    checks++; if (m_data !== 16'hA5C3) begin errors++; $display("FAIL single_data: got %h want a5c3", m_data); end
    checks++; if (spi_cs_n !== 4'b1101) begin errors++; $display("FAIL single_cs: got %b want 1101", spi_cs_n); end
    checks++; if (busy !== 1'b1 || grant_id !== 2'd1) begin errors++; $display("FAIL single_busy_grant: got %b/%0d want 1/1", busy, grant_id); end
    bad = 1'b0;
    for (int k = 1; k <= 32; k++) begin
      tick();
      if (req_done !== 4'b0000 || spi_cs_n !== 4'b1101 || m_start !== 1'b0) bad = 1'b1;
    end
    checks++; if (bad !== 1'b0) begin errors++; $display("FAIL single_wait_hold: got disturbance %b want 0", bad); end
    m_done = 1'b1; tick(); m_done = 1'b0;
    checks++; if (req_done !== 4'b0010) begin errors++; $display("FAIL single_done: got %b want 0010", req_done); end
    checks++; if (spi_cs_n !== 4'b1111 || req_err !== 4'b0000) begin errors++; $display("FAIL single_cs_release: got cs %b err %b want 1111 0000", spi_cs_n, req_err); end
    bad = 1'b0;
    for (int g = 1; g < GAP; g++) begin
      tick();
      if (spi_cs_n !== 4'b1111 || busy !== 1'b1 || req_done !== 4'b0000) bad = 1'b1;
    end
    checks++; if (bad !== 1'b0) begin errors++; $display("FAIL single_gap: got disturbance %b want 0", bad); end
    tick();
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL single_idle: got busy %b want 0", busy); end
  endtask

  task automatic test_fairness();
    int exp_order [6] = '{0, 1, 2, 3, 0, 1};
    int w;
    do_reset();
    for (int i = 0; i < NUM_REQ; i++) req_data[i*DATA_W +: DATA_W] = 16'hC000 + 16'(i);
    req_valid = 4'b1111;
    for (int k = 0; k < 6; k++) begin
      w = 0; #1;
      while (req_ready === 4'b0000 && w < 20) begin tick(); #1; w++; end
      if (k > 0) begin
        checks++; if (w !== GAP) begin errors++; $display("FAIL fair_gap%0d: got %0d cycles want %0d", k, w, GAP); end
      end
      checks++; if (req_ready !== 4'(1 << exp_order[k])) begin errors++; $display("FAIL fair_ready%0d: got %b want %b", k, req_ready, 4'(1 << exp_order[k])); end
      tick();
      checks++; if (grant_id !== 2'(exp_order[k]) || m_data !== 16'hC000 + 16'(exp_order[k])) begin errors++; $display("FAIL fair_grant%0d: got %0d/%h want %0d/%h", k, grant_id, m_data, exp_order[k], 16'hC000 + 16'(exp_order[k])); end
      checks++; if (spi_cs_n !== ~4'(1 << exp_order[k]) || m_start !== 1'b1) begin errors++; $display("FAIL fair_cs%0d: got %b/%b want %b/1", k, spi_cs_n, m_start, ~4'(1 << exp_order[k])); end
      tick(); tick();
      m_done = 1'b1; tick(); m_done = 1'b0;
      checks++; if (req_done !== 4'(1 << exp_order[k])) begin errors++; $display("FAIL fair_done%0d: got %b want %b", k, req_done, 4'(1 << exp_order[k])); end
    end
    req_valid = '0;
    for (int g = 0; g < GAP; g++) tick();
  endtask

  task automatic test_timeout();
    int k;
    bit bad;
    req_data[2*DATA_W +: DATA_W] = 16'h5A5A;
    req_valid = 4'b0100; #1;
    checks++; if (req_ready !== 4'b0100) begin errors++; $display("FAIL to_ready: got %b want 0100", req_ready); end
    tick(); req_valid = '0;
    checks++; if (m_start !== 1'b1 || spi_cs_n !== 4'b1011) begin errors++; $display("FAIL to_launch: got %b/%b want 1/1011", m_start, spi_cs_n); end
    k = 0; bad = 1'b0;
    while (req_err === 4'b0000 && k < 400) begin
      tick(); k++;
      if (req_done !== 4'b0000) bad = 1'b1;
    end
    checks++; if (k !== TO) begin errors++; $display("FAIL to_latency: got %0d cycles want %0d", k, TO); end
    checks++; if (req_err !== 4'b0100) begin errors++; $display("FAIL to_err: got %b want 0100", req_err); end
    checks++; if (spi_cs_n !== 4'b1111 || bad !== 1'b0) begin errors++; $display("FAIL to_release: got cs %b stray_done %b want 1111 0", spi_cs_n, bad); end
    tick();
    checks++; if (req_err !== 4'b0000 || busy !== 1'b1) begin errors++; $display("FAIL to_pulse: got err %b busy %b want 0000 1", req_err, busy); end
    tick(); tick(); tick();
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL to_idle: got busy %b want 0", busy); end
  endtask

  task automatic test_done_timeout_same();
    bit bad;
    req_data[3*DATA_W +: DATA_W] = 16'h0FF0;
    req_valid = 4'b1000; #1;
    checks++; if (req_ready !== 4'b1000) begin errors++; $display("FAIL dt_ready: got %b want 1000", req_ready); end
    tick(); req_valid = '0;
    bad = 1'b0;
    for (int k = 1; k < TO; k++) begin
      tick();
      if (req_err !== 4'b0000 || req_done !== 4'b0000) bad = 1'b1;
    end
    checks++; if (bad !== 1'b0) begin errors++; $display("FAIL dt_early: got early pulse %b want 0", bad); end
    m_done = 1'b1; tick(); m_done = 1'b0;
    checks++; if (req_done !== 4'b1000) begin errors++; $display("FAIL dt_done: got %b want 1000", req_done); end
    checks++; if (req_err !== 4'b0000) begin errors++; $display("FAIL dt_no_err: got %b want 0000", req_err); end
    tick();
    checks++; if (req_err !== 4'b0000) begin errors++; $display("FAIL dt_no_err_late: got %b want 0000", req_err); end
    tick(); tick(); tick();
  endtask

  task automatic test_stray_done();
    m_done = 1'b1; tick(); m_done = 1'b0; tick();
    checks++; if (req_done !== 4'b0000 || busy !== 1'b0 || spi_cs_n !== 4'b1111 || m_start !== 1'b0) begin errors++; $display("FAIL stray_idle: got done %b busy %b cs %b start %b want 0000 0 1111 0", req_done, busy, spi_cs_n, m_start); end
    req_valid = 4'b0001; #1;
    checks++; if (req_ready !== 4'b0001) begin errors++; $display("FAIL stray_ready: got %b want 0001", req_ready); end
    tick(); req_valid = '0;
    tick();
    m_done = 1'b1; tick();
    checks++; if (req_done !== 4'b0001) begin errors++; $display("FAIL stray_done_real: got %b want 0001", req_done); end
    tick(); m_done = 1'b0;
    checks++; if (req_done !== 4'b0000 || spi_cs_n !== 4'b1111) begin errors++; $display("FAIL stray_gap: got done %b cs %b want 0000 1111", req_done, spi_cs_n); end
    tick();
    checks++; if (req_done !== 4'b0000 || busy !== 1'b1) begin errors++; $display("FAIL stray_gap2: got done %b busy %b want 0000 1", req_done, busy); end
    tick(); tick();
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL stray_gap_len: got busy %b want 0", busy); end
  endtask

  task automatic test_reset_mid();
    req_data[2*DATA_W +: DATA_W] = 16'h1234;
    req_valid = 4'b0100; #1;
    checks++; if (req_ready !== 4'b0100) begin errors++; $display("FAIL rm_ready: got %b want 0100", req_ready); end
    tick(); req_valid = '0;
    tick(); tick();
    checks++; if (spi_cs_n !== 4'b1011) begin errors++; $display("FAIL rm_cs_low: got %b want 1011", spi_cs_n); end
    rst = 1'b0; #1;
    checks++; if (spi_cs_n !== 4'b1111 || busy !== 1'b0) begin errors++; $display("FAIL rm_async: got cs %b busy %b want 1111 0", spi_cs_n, busy); end
    checks++; if (grant_id !== 2'd0 || m_data !== 16'h0000 || m_start !== 1'b0) begin errors++; $display("FAIL rm_values: got %0d/%h/%b want 0/0000/0", grant_id, m_data, m_start); end
    tick();
    checks++; if (req_done !== 4'b0000 || req_err !== 4'b0000) begin errors++; $display("FAIL rm_no_pulse: got %b/%b want 0000/0000", req_done, req_err); end
    rst = 1'b1; req_valid = 4'b1111; #1;
    checks++; if (req_ready !== 4'b0001) begin errors++; $display("FAIL rm_ready0: got %b want 0001", req_ready); end
    tick(); req_valid = '0;
    checks++; if (grant_id !== 2'd0 || spi_cs_n !== 4'b1110) begin errors++; $display("FAIL rm_grant0: got %0d/%b want 0/1110", grant_id, spi_cs_n); end
    tick();
    m_done = 1'b1; tick(); m_done = 1'b0;
    checks++; if (req_done !== 4'b0001) begin errors++; $display("FAIL rm_done0: got %b want 0001", req_done); end
  endtask

  initial begin
    test_reset();
    test_single();
    test_fairness();
    test_timeout();
    test_done_timeout_same();
    test_stray_done();
    test_reset_mid();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
